// File: rtl/l2_burst_adapter.sv
// rtl/l2_burst_adapter.sv - L2 line request to fixed-length memory beat burst adapter
// Reads reassemble BEATS beats into one line; writes split the latched line into beats.
module l2_burst_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((LINE_W / 8) - 1));

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [LINE_W-1:0]  line_buf;
  logic [LINE_W-1:0]  merged;
  logic               beat;
  logic               last;
  logic               accept;

  // resp_i only counts while a burst is actually in flight
  assign beat   = resp_i && ((state == RD) || (state == WR));
  assign last   = beat && (cnt == CNT_W'(BEATS - 1));
  assign accept = (state == IDLE) && (read_i || write_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (write_i) begin
          state_nxt = WR;
        end else if (read_i) begin
          state_nxt = RD;
        end
      end
      RD:      if (last) state_nxt = DONE;
      WR:      if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read assembly reuses the write line buffer; line_o only updates on the final beat
  always_comb begin
    merged = line_buf;
    merged[cnt*BEAT_W +: BEAT_W] = burst_i;
  end

  always_comb begin
    burst_o = '0;
    if (state == WR) begin
      burst_o = line_buf[cnt*BEAT_W +: BEAT_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      line_buf  <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      read_o  <= (state_nxt == RD);
      write_o <= (state_nxt == WR);
      resp_o  <= (state_nxt == DONE);
      if (accept) begin
        address_o <= address_i & ALIGN_MASK;
        cnt       <= '0;
        if (write_i) begin
          line_buf <= line_i;
        end
      end
      if (beat) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (state == RD) begin
          line_buf <= merged;
          if (last) begin
            line_o <= merged;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_burst_adapter.sv
// tb/tb_l2_burst_adapter.sv - directed table-driven bench for l2_burst_adapter
module tb_l2_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l2_burst_adapter #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  typedef struct {
    logic            rd;
    logic            wr;
    logic [31:0]     addr;
    logic [255:0]    wline;
    logic [3:0][63:0] beats;
    logic [7:0]      pat;
    int              plen;
    logic [31:0]     exp_addr;
    logic [3:0][63:0] exp_wb;
    logic [255:0]    exp_line;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int b;
    logic exp_rd;
    exp_rd = v.rd && !v.wr;
    @(posedge clk); #1;
    address_i = v.addr; read_i = v.rd; write_i = v.wr; line_i = v.wline; resp_i = 1'b0;
    @(posedge clk); #1;
    line_i = {4{64'h5A5A_5A5A_5A5A_5A5A}};
    b = 0;
    for (int k = 0; k < v.plen; k++) begin
      resp_i  = v.pat[k];
      burst_i = v.pat[k] ? v.beats[b] : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      chk($sformatf("v%0d c%0d read_o", idx, k), read_o, exp_rd);
      chk($sformatf("v%0d c%0d write_o", idx, k), write_o, v.wr);
      chk($sformatf("v%0d c%0d address_o", idx, k), address_o, v.exp_addr);
      chk($sformatf("v%0d c%0d resp_o", idx, k), resp_o, 1'b0);
      if (v.wr && v.pat[k]) chk($sformatf("v%0d beat%0d burst_o", idx, b), burst_o, v.exp_wb[b]);
      if (v.pat[k]) b++;
      @(posedge clk); #1;
    end
    resp_i = 1'b0; burst_i = '0;
    @(negedge clk);
    chk($sformatf("v%0d done resp_o", idx), resp_o, 1'b1);
    chk($sformatf("v%0d done read_o", idx), read_o, 1'b0);
    chk($sformatf("v%0d done write_o", idx), write_o, 1'b0);
    chk($sformatf("v%0d done line_o", idx), line_o, v.exp_line);
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d idle resp_o", idx), resp_o, 1'b0);
    chk($sformatf("v%0d idle line_o", idx), line_o, v.exp_line);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'h0,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                8'b0000_1111, 4, 32'h0000_1220, '0,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_805F,
                256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA,
                '0, 8'b0000_1111, 4, 32'h0000_8040,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
    vecs[2] = '{1'b1, 1'b0, 32'h1000_0001, 256'h0,
                {64'hF0F0_F0F0_0000_0001, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                8'b0110_1001, 7, 32'h1000_0000, '0,
                256'hF0F0F0F000000001_0F0F0F0F0F0F0F0F_FEDCBA9876543210_0123456789ABCDEF};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0ABC,
                256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001,
                '0, 8'b0001_1011, 5, 32'h0000_0AA0,
                {64'h4, 64'h3, 64'h2, 64'h1},
                256'hF0F0F0F000000001_0F0F0F0F0F0F0F0F_FEDCBA9876543210_0123456789ABCDEF};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFE0, 256'h0,
                {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
                8'b0000_1111, 4, 32'hFFFF_FFE0, '0,
                256'hCAFE000000000003_CAFE000000000002_CAFE000000000001_CAFE000000000000};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_003F, 256'h0,
                {64'h8000_0000_0000_0008, 64'h7000_0000_0000_0007, 64'h6000_0000_0000_0006, 64'h5000_0000_0000_0005},
                8'b0000_1111, 4, 32'h0000_0020, '0,
                256'h8000000000000008_7000000000000007_6000000000000006_5000000000000005};

    rst = 1'b0; address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0; burst_i = '0; resp_i = 1'b0;
    #3;
    chk("reset read_o", read_o, 1'b0);
    chk("reset write_o", write_o, 1'b0);
    chk("reset resp_o", resp_o, 1'b0);
    chk("reset address_o", address_o, 32'h0);
    chk("reset line_o", line_o, 256'h0);
    chk("reset burst_o", burst_o, 64'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 4; i++) run(vecs[i], i);

    // spurious acks in IDLE must not capture or advance
    @(posedge clk); #1;
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      chk("spurious read_o", read_o, 1'b0);
      chk("spurious resp_o", resp_o, 1'b0);
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    @(negedge clk);
    chk("spurious line_o", line_o, vecs[2].exp_line);
    run(vecs[4], 4);

    // reset during beat 2 of a write burst
    @(posedge clk); #1;
    address_i = 32'h0000_4000; write_i = 1'b1; line_i = vecs[1].wline;
    @(posedge clk); #1;
    resp_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resp_i = 1'b0;
    @(negedge clk);
    chk("pre-reset write_o", write_o, 1'b1);
    chk("pre-reset burst_o", burst_o, 64'hCCCC_CCCC_CCCC_CCCC);
    #1 rst = 1'b0;
    #1;
    chk("midreset write_o", write_o, 1'b0);
    chk("midreset read_o", read_o, 1'b0);
    chk("midreset resp_o", resp_o, 1'b0);
    chk("midreset burst_o", burst_o, 64'h0);
    chk("midreset line_o", line_o, 256'h0);
    write_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post-reset write_o", write_o, 1'b0);
      chk("post-reset resp_o", resp_o, 1'b0);
      chk("post-reset burst_o", burst_o, 64'h0);
    end
    run(vecs[5], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
